// File: rtl/pixel_row_streamer.sv
// Streams a binarized image row by row from row memory into a sliding
// HistDepth-bit history window that drives a flip-flop register bank.
module pixel_row_streamer #(
  parameter int NrOfRows  = 28,
  parameter int NrOfCols  = 28,
  parameter int HistDepth = 8,
  parameter int AddrBits  = 5
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 row_rd,
  output logic [AddrBits-1:0]  row_addr,
  input  logic [NrOfCols-1:0]  row_data,
  output logic [HistDepth-1:0] hist_d,
  output logic                 hist_we,
  output logic [AddrBits-1:0]  pix_row,
  output logic [4:0]           pix_col
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [AddrBits-1:0] LAST_ROW = AddrBits'(NrOfRows - 1);
  localparam logic [4:0]          LAST_COL = 5'(NrOfCols - 1);

  state_t                state_q, state_d;
  logic [AddrBits-1:0]   row_q, row_d;
  logic [4:0]            col_q, col_d;
  logic [NrOfCols-1:0]   row_buf_q, row_buf_d;
  logic [HistDepth-1:0]  win_q, win_d;
  logic                  we_q, we_d;
  logic [AddrBits-1:0]   pix_row_q, pix_row_d;
  logic [4:0]            pix_col_q, pix_col_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      row_buf_q <= '0;
      win_q     <= '0;
      we_q      <= 1'b0;
      pix_row_q <= '0;
      pix_col_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      row_buf_q <= row_buf_d;
      win_q     <= win_d;
      we_q      <= we_d;
      pix_row_q <= pix_row_d;
      pix_col_q <= pix_col_d;
    end
  end

  // The row buffer shifts left as pixels are consumed, so its MSB is always
  // the next pixel and no variable column index is needed.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    row_buf_d = row_buf_q;
    win_d     = win_q;
    we_d      = we_q;
    pix_row_d = pix_row_q;
    pix_col_d = pix_col_q;
    if (Tick) begin
      we_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            row_d   = '0;
          end
        end
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          row_buf_d = row_data;
          win_d     = '0;
          col_d     = '0;
          state_d   = S_SHIFT;
        end
        S_SHIFT: begin
          win_d     = HistDepth'({win_q, row_buf_q[NrOfCols-1]});
          row_buf_d = row_buf_q << 1;
          we_d      = 1'b1;
          pix_row_d = row_q;
          pix_col_d = col_q;
          if (col_q == LAST_COL) begin
            if (row_q == LAST_ROW) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + AddrBits'(1);
              state_d = S_FETCH;
            end
          end else begin
            col_d = col_q + 5'd1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are qualified by Tick so the bank only sees them on enabled cycles.
  assign busy     = (state_q != S_IDLE);
  assign done     = Tick && (state_q == S_DONE);
  assign row_rd   = Tick && (state_q == S_FETCH);
  assign row_addr = row_q;
  assign hist_d   = win_q;
  assign hist_we  = Tick && we_q;
  assign pix_row  = pix_row_q;
  assign pix_col  = pix_col_q;

endmodule

// File: tb/tb_pixel_row_streamer.sv
// Directed bench for pixel_row_streamer: a 28x28 instance plus a 2x4 instance
// with HistDepth=4, each fed by a 1-cycle-latency row memory model.
module tb_pixel_row_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tick, start, start_s;

  logic        busy, done, row_rd, hist_we;
  logic [4:0]  row_addr, pix_row, pix_col;
  logic [27:0] row_data = '0;
  logic [7:0]  hist_d;

  logic        busy_s, done_s, row_rd_s, hist_we_s;
  logic [0:0]  row_addr_s, pix_row_s;
  logic [4:0]  pix_col_s;
  logic [3:0]  row_data_s = '0;
  logic [3:0]  hist_d_s;

  logic [27:0] mem   [0:27];
  logic [3:0]  mem_s [0:1];

  pixel_row_streamer dut (
    .Clock(clk), .Reset(rst), .Tick(tick), .start(start),
    .busy(busy), .done(done), .row_rd(row_rd), .row_addr(row_addr),
    .row_data(row_data), .hist_d(hist_d), .hist_we(hist_we),
    .pix_row(pix_row), .pix_col(pix_col)
  );

  pixel_row_streamer #(.NrOfRows(2), .NrOfCols(4), .HistDepth(4), .AddrBits(1)) dut_s (
    .Clock(clk), .Reset(rst), .Tick(tick), .start(start_s),
    .busy(busy_s), .done(done_s), .row_rd(row_rd_s), .row_addr(row_addr_s),
    .row_data(row_data_s), .hist_d(hist_d_s), .hist_we(hist_we_s),
    .pix_row(pix_row_s), .pix_col(pix_col_s)
  );

  always @(posedge clk) begin
    if (row_rd)   row_data   <= mem[row_addr];
    if (row_rd_s) row_data_s <= mem_s[row_addr_s];
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Window after the k-th pixel (1-based) of row 28'h8000001 with depth 8.
  function automatic logic [31:0] pat1(input int k);
    if (k <= 8)   return 32'(1) << (k - 1);
    if (k == 28)  return 32'h01;
    return 32'h00;
  endfunction

  int         we_cnt, rd_cnt, done_idx, busy_low;
  logic [7:0] cap0      [0:27];
  logic [7:0] row_first [0:27];

  task automatic run_pass(input bit toggle, input bit chk_pat, input int stop_row, input int stop_col);
    int k;
    we_cnt = 0; rd_cnt = 0; done_idx = -1; busy_low = 0;
    tick = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      tick = toggle ? (n % 2 == 1) : 1'b1;
      @(negedge clk);
      if (!busy) busy_low++;
      if (row_rd) begin
        chk("row_addr", row_addr, rd_cnt);
        rd_cnt++;
      end
      if (hist_we) begin
        k = we_cnt % 28;
        chk("we_only_on_tick", tick, 1);
        chk("pix_row", pix_row, we_cnt / 28);
        chk("pix_col", pix_col, k);
        if (we_cnt < 28) cap0[k] = hist_d;
        if (k == 0 && we_cnt / 28 < 28) row_first[we_cnt / 28] = hist_d;
        if (chk_pat) chk("hist_d_pat", hist_d, pat1(k + 1));
        we_cnt++;
        if (stop_row >= 0 && (we_cnt - 1) == stop_row * 28 + stop_col) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          return;
        end
      end
      if (done) begin
        done_idx = n;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    tick = 1'b1;
  endtask

  logic [7:0] exp_t2 [0:9];
  logic [3:0] exp_s  [0:7];
  logic [3:0] cap_s  [0:7];
  int d1, d2, ndone, we_s, done_s_idx;
  logic b841, b842, rd842;
  logic [4:0] a842;

  initial begin
    exp_t2 = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h15, 8'h2A, 8'h55, 8'hAA, 8'h55, 8'hAA};
    exp_s  = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h0, 4'h1, 4'h3, 4'h6};
    for (int r = 0; r < 28; r++) mem[r] = 28'h8000001;
    mem_s[0] = 4'b1001;
    mem_s[1] = 4'b0110;

    // Reset overrides Tick and start
    rst = 1'b1; tick = 1'b1; start = 1'b1; start_s = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_row_rd", row_rd, 0);
    chk("rst_row_addr", row_addr, 0);
    chk("rst_hist_d", hist_d, 0);
    chk("rst_hist_we", hist_we, 0);
    chk("rst_pix_row", pix_row, 0);
    chk("rst_pix_col", pix_col, 0);
    chk("rst_busy_s", busy_s, 0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; start_s = 1'b0;
    @(posedge clk); #1;

    // Test 1: full pass, Tick high
    run_pass(1'b0, 1'b1, -1, -1);
    chk("t1_done_idx", done_idx, 840);
    chk("t1_we_cnt", we_cnt, 784);
    chk("t1_rd_cnt", rd_cnt, 28);
    chk("t1_busy_low_in_pass", busy_low, 0);
    chk("t1_busy_after", busy, 0);
    chk("t1_last_pix_row", pix_row, 27);
    chk("t1_last_pix_col", pix_col, 27);

    // Test 2: alternating row 0, window cleared at row 1
    mem[0] = 28'hAAAAAAA;
    run_pass(1'b0, 1'b0, -1, -1);
    for (int i = 0; i < 10; i++) chk("t2_seq", cap0[i], exp_t2[i]);
    chk("t2_row0_last", cap0[27], 8'hAA);
    chk("t2_row1_first", row_first[1], 8'h01);
    chk("t2_done_idx", done_idx, 840);
    mem[0] = 28'h8000001;

    // Test 3: Tick toggling
    run_pass(1'b1, 1'b1, -1, -1);
    chk("t3_done_idx", done_idx, 1681);
    chk("t3_we_cnt", we_cnt, 784);
    chk("t3_rd_cnt", rd_cnt, 28);

    // Test 4: reset mid-SHIFT at row 5 col 10, then clean pass
    run_pass(1'b0, 1'b1, 5, 10);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_row_rd", row_rd, 0);
    chk("t4_row_addr", row_addr, 0);
    chk("t4_hist_d", hist_d, 0);
    chk("t4_hist_we", hist_we, 0);
    chk("t4_pix_row", pix_row, 0);
    chk("t4_pix_col", pix_col, 0);
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) ndone++;
      @(posedge clk); #1;
    end
    chk("t4_idle_after_reset", ndone, 0);
    run_pass(1'b0, 1'b1, -1, -1);
    chk("t4_restart_done_idx", done_idx, 840);
    chk("t4_restart_we_cnt", we_cnt, 784);

    // Test 5: start held high
    d1 = -1; d2 = -1; ndone = 0;
    b841 = 1'b1; b842 = 1'b0; rd842 = 1'b0; a842 = '1;
    tick = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n == 841) b841 = busy;
      if (n == 842) begin b842 = busy; rd842 = row_rd; a842 = row_addr; end
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = n;
        else begin
          d2 = n;
          start = 1'b0;
          break;
        end
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("t5_done1", d1, 840);
    chk("t5_done2", d2, 1682);
    chk("t5_idle_gap_busy", b841, 0);
    chk("t5_restart_busy", b842, 1);
    chk("t5_restart_row_rd", rd842, 1);
    chk("t5_restart_row_addr", a842, 0);
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) ndone++;
      @(posedge clk); #1;
    end
    chk("t5_no_extra_pass", ndone, 0);

    // Test 6: small instance 2x4, depth 4
    we_s = 0; done_s_idx = -1;
    for (int i = 0; i < 8; i++) cap_s[i] = '0;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (hist_we_s) begin
        if (we_s < 8) cap_s[we_s] = hist_d_s;
        we_s++;
      end
      if (done_s) begin
        done_s_idx = n;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) chk("t6_hist_d", cap_s[i], exp_s[i]);
    chk("t6_we_cnt", we_s, 8);
    chk("t6_done_idx", done_s_idx, 12);
    chk("t6_pix_row", pix_row_s, 1);
    chk("t6_pix_col", pix_col_s, 3);
    chk("t6_busy_after", busy_s, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
